// File: rtl/hdc_raw_frame_packer.sv
// Packs a channel-ordered stream of ADC samples into ping-pong buffered RAW_WIDTH frames
// with mode/label sideband, presented downstream over a valid/ready handshake.
`timescale 1ns/1ps
`ifndef MODE_WIDTH
`define MODE_WIDTH 2
`endif
`ifndef LABEL_WIDTH
`define LABEL_WIDTH 4
`endif

module hdc_raw_frame_packer #(
  parameter int NUM_CH       = 64,
  parameter int SLOT_WIDTH   = 16,
  parameter int SAMPLE_WIDTH = 15,
  parameter int MODE_W       = `MODE_WIDTH,
  parameter int LABEL_W      = `LABEL_WIDTH,
  localparam int RAW_WIDTH   = NUM_CH * SLOT_WIDTH
) (
  input  logic                 Clk_CI,
  input  logic                 Reset_RI,
  input  logic                 ValidIn_SI,
  output logic                 ReadyOut_SO,
  input  logic                 SofIn_SI,
  input  logic [15:0]          SampleIn_DI,
  input  logic [MODE_W-1:0]    ModeIn_SI,
  input  logic [LABEL_W-1:0]   LabelIn_DI,
  output logic                 ValidOut_SO,
  input  logic                 ReadyIn_SI,
  output logic [RAW_WIDTH-1:0] Raw_DO,
  output logic [MODE_W-1:0]    ModeOut_SO,
  output logic [LABEL_W-1:0]   LabelOut_DO,
  output logic                 FrameErr_SO,
  output logic [15:0]          FrameCnt_DO
);

  localparam int CNT_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           full_q, full_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;

  logic [RAW_WIDTH-1:0] buf_q [2];
  logic [RAW_WIDTH-1:0] buf_d [2];
  logic [MODE_W-1:0]    mode_q [2];
  logic [MODE_W-1:0]    mode_d [2];
  logic [LABEL_W-1:0]   label_q [2];
  logic [LABEL_W-1:0]   label_d [2];

  logic                  in_xfer;
  logic                  out_xfer;
  logic                  wr_en;
  logic                  cap_side;
  logic [CNT_W-1:0]      wr_slot;
  logic [SLOT_WIDTH-1:0] slot_val;
  logic                  unused_sample_msb;

  assign unused_sample_msb = ^SampleIn_DI[15:SAMPLE_WIDTH];

  assign in_xfer  = ValidIn_SI & ready_q;
  assign out_xfer = full_q[rd_ptr_q] & ReadyIn_SI;
  assign slot_val = {{(SLOT_WIDTH - SAMPLE_WIDTH){1'b0}}, SampleIn_DI[SAMPLE_WIDTH-1:0]};

  // Write FSM, buffer bookkeeping and downstream handshake
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    full_d      = full_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = 1'b0;
    wr_en       = 1'b0;
    cap_side    = 1'b0;
    wr_slot     = cnt_q;

    if (in_xfer) begin
      if (SofIn_SI) begin
        // A SOF inside a frame restarts it in the same buffer; stale slots get overwritten.
        err_d    = (state_q == S_FILL);
        state_d  = S_FILL;
        cnt_d    = CNT_W'(1);
        wr_slot  = '0;
        wr_en    = 1'b1;
        cap_side = 1'b1;
      end else if (state_q == S_IDLE) begin
        err_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (cnt_q == LAST_CH) begin
          full_d[wr_ptr_q] = 1'b1;
          wr_ptr_d         = ~wr_ptr_q;
          state_d          = S_IDLE;
          cnt_d            = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    if (out_xfer) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
      frame_cnt_d      = frame_cnt_q + 16'd1;
    end

    ready_d = ~full_d[wr_ptr_d];
  end

  always_comb begin
    buf_d   = buf_q;
    mode_d  = mode_q;
    label_d = label_q;
    if (wr_en) begin
      buf_d[wr_ptr_q][int'(wr_slot) * SLOT_WIDTH +: SLOT_WIDTH] = slot_val;
    end
    if (cap_side) begin
      mode_d[wr_ptr_q]  = ModeIn_SI;
      label_d[wr_ptr_q] = LabelIn_DI;
    end
  end

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      full_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Payload storage carries no reset; an empty buffer is never presented.
  always_ff @(posedge Clk_CI) begin
    buf_q   <= buf_d;
    mode_q  <= mode_d;
    label_q <= label_d;
  end

  assign ReadyOut_SO = ready_q;
  assign ValidOut_SO = full_q[rd_ptr_q];
  assign Raw_DO      = full_q[rd_ptr_q] ? buf_q[rd_ptr_q]   : '0;
  assign ModeOut_SO  = full_q[rd_ptr_q] ? mode_q[rd_ptr_q]  : '0;
  assign LabelOut_DO = full_q[rd_ptr_q] ? label_q[rd_ptr_q] : '0;
  assign FrameErr_SO = err_q;
  assign FrameCnt_DO = frame_cnt_q;

endmodule

// File: tb/tb_hdc_raw_frame_packer.sv
// Scoreboard bench for hdc_raw_frame_packer: a frame-level model of the sample stream feeds an
// expected-frame queue that an independent output monitor drains and compares.
`timescale 1ns/1ps
`ifndef MODE_WIDTH
`define MODE_WIDTH 2
`endif
`ifndef LABEL_WIDTH
`define LABEL_WIDTH 4
`endif

module tb_hdc_raw_frame_packer;

  localparam int NUM_CH = 64;
  localparam int RAW_W  = 1024;
  localparam int MW     = `MODE_WIDTH;
  localparam int LW     = `LABEL_WIDTH;

  logic             Clk_CI = 1'b0;
  logic             Reset_RI = 1'b1;
  logic             ValidIn_SI = 1'b0;
  logic             ReadyOut_SO;
  logic             SofIn_SI = 1'b0;
  logic [15:0]      SampleIn_DI = '0;
  logic [MW-1:0]    ModeIn_SI = '0;
  logic [LW-1:0]    LabelIn_DI = '0;
  logic             ValidOut_SO;
  logic             ReadyIn_SI = 1'b0;
  logic [RAW_W-1:0] Raw_DO;
  logic [MW-1:0]    ModeOut_SO;
  logic [LW-1:0]    LabelOut_DO;
  logic             FrameErr_SO;
  logic [15:0]      FrameCnt_DO;

  hdc_raw_frame_packer dut (
    .Clk_CI(Clk_CI), .Reset_RI(Reset_RI), .ValidIn_SI(ValidIn_SI), .ReadyOut_SO(ReadyOut_SO),
    .SofIn_SI(SofIn_SI), .SampleIn_DI(SampleIn_DI), .ModeIn_SI(ModeIn_SI),
    .LabelIn_DI(LabelIn_DI), .ValidOut_SO(ValidOut_SO), .ReadyIn_SI(ReadyIn_SI),
    .Raw_DO(Raw_DO), .ModeOut_SO(ModeOut_SO), .LabelOut_DO(LabelOut_DO),
    .FrameErr_SO(FrameErr_SO), .FrameCnt_DO(FrameCnt_DO)
  );

  always #5 Clk_CI = ~Clk_CI;

  typedef struct {
    logic [RAW_W-1:0] raw;
    logic [MW-1:0]    mode;
    logic [LW-1:0]    label;
  } frame_t;

  frame_t      exp_q[$];
  logic [14:0] cur[$];
  int          in_frame;
  logic [MW-1:0] cur_mode;
  logic [LW-1:0] cur_label;

  int n_chk = 0, n_err = 0;
  int exp_err = 0, obs_err = 0, mon_cnt = 0, frames_out = 0, acc_cnt = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [RAW_W-1:0] act, input logic [RAW_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    cur.delete();
    in_frame = 0; exp_err = 0; obs_err = 0; mon_cnt = 0; frames_out = 0; acc_cnt = 0;
  endtask

  // Frame-level reference: collect accepted samples, emit a frame after NUM_CH of them.
  task automatic model_accept(input logic [15:0] s, input logic sof,
                              input logic [MW-1:0] m, input logic [LW-1:0] l);
    frame_t f;
    acc_cnt++;
    if (sof) begin
      if (in_frame != 0) exp_err++;
      cur.delete();
      in_frame  = 1;
      cur_mode  = m;
      cur_label = l;
      cur.push_back(s[14:0]);
    end else if (in_frame == 0) begin
      exp_err++;
    end else begin
      cur.push_back(s[14:0]);
    end
    if (in_frame != 0 && cur.size() == NUM_CH) begin
      f.raw = '0;
      for (int k = 0; k < NUM_CH; k++) f.raw[k*16 +: 16] = {1'b0, cur[k]};
      f.mode  = cur_mode;
      f.label = cur_label;
      exp_q.push_back(f);
      in_frame = 0;
      cur.delete();
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the sample was taken.
  task automatic send(input logic [15:0] s, input logic sof,
                      input logic [MW-1:0] m, input logic [LW-1:0] l);
    int  guard;
    logic acc;
    SampleIn_DI = s; SofIn_SI = sof; ModeIn_SI = m; LabelIn_DI = l; ValidIn_SI = 1'b1;
    guard = 0; acc = 1'b0;
    while (!acc && guard < 5000) begin
      acc = ReadyOut_SO;
      @(negedge Clk_CI);
      guard++;
    end
    ValidIn_SI = 1'b0; SofIn_SI = 1'b0;
    if (acc) model_accept(s, sof, m, l);
    else chk("send_timeout", {1023'd0, ReadyOut_SO}, 1);
  endtask

  task automatic send_frame(input logic [MW-1:0] m, input logic [LW-1:0] l, input int gaps);
    for (int k = 0; k < NUM_CH; k++) begin
      if (gaps != 0 && $urandom_range(0, 31) == 0) @(negedge Clk_CI);
      send(16'($urandom), (k == 0), m, l);
    end
  endtask

  task automatic apply_reset();
    Reset_RI = 1'b1; ValidIn_SI = 1'b0; SofIn_SI = 1'b0;
    model_clear();
    repeat (2) @(negedge Clk_CI);
    Reset_RI = 1'b0;
  endtask

  task automatic drain(input string name, input int want_cnt);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 4000) begin
      @(negedge Clk_CI);
      g++;
    end
    repeat (3) @(negedge Clk_CI);
    #1;
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_framecnt"}, FrameCnt_DO, 16'(want_cnt));
    chk({name, "_errcnt"}, obs_err, exp_err);
  endtask

  initial begin
    forever begin
      @(negedge Clk_CI);
      case (rdy_mode)
        0:       ReadyIn_SI = 1'b1;
        1:       ReadyIn_SI = 1'b0;
        default: ReadyIn_SI = ($urandom_range(0, 99) < 5);
      endcase
    end
  end

  // Output monitor: samples just after the falling edge, ahead of the next rising edge.
  initial begin
    logic             held;
    logic [RAW_W-1:0] held_raw;
    frame_t           f;
    held = 1'b0;
    held_raw = '0;
    forever begin
      @(negedge Clk_CI);
      #1;
      if (Reset_RI) begin
        held = 1'b0;
        continue;
      end
      obs_err += int'(FrameErr_SO);
      if (held) begin
        chk("stall_valid", {1023'd0, ValidOut_SO}, 1);
        chk("stall_raw", Raw_DO, held_raw);
      end
      if (ValidOut_SO && ReadyIn_SI) begin
        chk("framecnt_at_xfer", FrameCnt_DO, 16'(mon_cnt));
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {1023'd0, ValidOut_SO}, 0);
        end else begin
          f = exp_q.pop_front();
          chk("frame_raw", Raw_DO, f.raw);
          chk("frame_mode", ModeOut_SO, f.mode);
          chk("frame_label", LabelOut_DO, f.label);
        end
        mon_cnt++;
        frames_out++;
      end
      held = ValidOut_SO & ~ReadyIn_SI;
      held_raw = Raw_DO;
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    model_clear();
    @(negedge Clk_CI);

    // T1: reset state, then one frame with MSB-set samples
    apply_reset();
    #1;
    chk("rst_valid", {1023'd0, ValidOut_SO}, 0);
    chk("rst_ready", {1023'd0, ReadyOut_SO}, 1);
    chk("rst_err", {1023'd0, FrameErr_SO}, 0);
    chk("rst_cnt", FrameCnt_DO, 0);
    chk("rst_raw", Raw_DO, 0);
    @(negedge Clk_CI);
    rdy_mode = 0;
    for (int k = 0; k < NUM_CH; k++) send(16'h8000 | 16'(k), (k == 0), MW'(1), LW'(3));
    drain("t1", 1);

    // T2: three back-to-back frames against a stalled consumer
    apply_reset();
    rdy_mode = 1;
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(MW'($urandom), LW'($urandom), 0);
      end
      begin
        g = 0;
        while (acc_cnt < 2 * NUM_CH && g < 1000) begin
          @(negedge Clk_CI);
          #1;
          g++;
        end
        chk("t2_ready_low", {1023'd0, ReadyOut_SO}, 0);
        chk("t2_valid", {1023'd0, ValidOut_SO}, 1);
        repeat (10) @(negedge Clk_CI);
        #1;
        chk("t2_ready_held", {1023'd0, ReadyOut_SO}, 0);
        chk("t2_no_extra_accept", acc_cnt, 2 * NUM_CH);
        rdy_mode = 0;
      end
    join
    drain("t2", 3);

    // T3: SOF in the middle of a frame restarts it
    apply_reset();
    rdy_mode = 0;
    for (int k = 0; k < 20; k++) send(16'($urandom), (k == 0), MW'(2), LW'(5));
    send_frame(MW'(1), LW'(9), 0);
    drain("t3", 1);
    chk("t3_frames", frames_out, 1);
    chk("t3_errs", obs_err, 1);

    // T4: samples without SOF from IDLE are dropped with an error each
    apply_reset();
    for (int k = 0; k < 5; k++) send(16'($urandom), 1'b0, '0, '0);
    repeat (3) @(negedge Clk_CI);
    #1;
    chk("t4_errs", obs_err, 5);
    chk("t4_ready", {1023'd0, ReadyOut_SO}, 1);
    chk("t4_valid", {1023'd0, ValidOut_SO}, 0);
    chk("t4_frames", frames_out, 0);
    @(negedge Clk_CI);

    // T5: asynchronous reset with one frame pending and another half written
    apply_reset();
    rdy_mode = 0;
    send_frame(MW'(3), LW'(1), 0);
    drain("t5a", 1);
    rdy_mode = 1;
    send_frame(MW'(2), LW'(2), 0);
    for (int k = 0; k < 10; k++) send(16'($urandom), (k == 0), MW'(1), LW'(4));
    #2;
    Reset_RI = 1'b1;
    #1;
    chk("t5_valid", {1023'd0, ValidOut_SO}, 0);
    chk("t5_cnt", FrameCnt_DO, 0);
    chk("t5_ready", {1023'd0, ReadyOut_SO}, 1);
    model_clear();
    repeat (2) @(negedge Clk_CI);
    Reset_RI = 1'b0;
    rdy_mode = 0;
    send_frame(MW'(1), LW'(6), 0);
    drain("t5b", 1);

    // T6: long random run with input gaps and a mostly stalled consumer
    apply_reset();
    rdy_mode = 2;
    for (int f = 0; f < 1000; f++) send_frame(MW'($urandom), LW'($urandom), 1);
    rdy_mode = 0;
    drain("t6", 1000 % 65536);
    chk("t6_frames", frames_out, 1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
